// File: rtl/imm_encoder.sv
// imm_encoder: packs LEGv8 fields into 32-bit instruction words, expanding wide constants into MOVZ/MOVK.
// Optional IMM_ENC_PERF_EN adds saturating handshake counters perf_words/perf_errs.
module imm_encoder #(
    parameter int WORD      = 64,
    parameter int INSTR_LEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_fmt,
    input  logic [10:0]          req_opcode,
    input  logic [4:0]           req_rd,
    input  logic [4:0]           req_rn,
    input  logic [WORD-1:0]      req_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INSTR_LEN-1:0] out_instr,
    output logic                 out_last,
    output logic                 out_err
`ifdef IMM_ENC_PERF_EN
    ,
    output logic [31:0]          perf_words,
    output logic [15:0]          perf_errs
`endif
);
    typedef enum logic [1:0] {IDLE, HOLD, WIDE} state_t;
    localparam logic [8:0] MOVZ = 9'b110100101;
    localparam logic [8:0] MOVK = 9'b111100101;

    state_t                 state, state_nxt;
    logic signed [WORD-1:0] simm;
    logic [3:0]             nz, first_rem, rem, rem_nxt;
    logic [1:0]             first_hw, next_hw;
    logic [WORD-1:0]        wimm;
    logic [4:0]             wrd;
    logic [INSTR_LEN-1:0]   enc_word, wide_first, wide_next;
    logic                   enc_err, accept, advance;

    function automatic logic [1:0] low_idx(input logic [3:0] m);
        return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : m[3] ? 2'd3 : 2'd0;
    endfunction

    assign simm = $signed(req_imm);

    // rem holds the nonzero halfwords still to be emitted as MOVK, lowest first
    always_comb begin
        nz         = {|req_imm[63:48], |req_imm[47:32], |req_imm[31:16], |req_imm[15:0]};
        first_hw   = low_idx(nz);
        first_rem  = nz & ~(4'b1 << first_hw);
        wide_first = {MOVZ, first_hw, req_imm[{first_hw, 4'b0} +: 16], req_rd};
        next_hw    = low_idx(rem);
        rem_nxt    = rem & ~(4'b1 << next_hw);
        wide_next  = {MOVK, next_hw, wimm[{next_hw, 4'b0} +: 16], wrd};
    end

    always_comb begin
        enc_word = '0;
        enc_err  = 1'b0;
        case (req_fmt)
            3'd0: begin
                enc_err  = simm < 64'sd0 || simm > 64'sd63;
                enc_word = {req_opcode, 5'b0, req_imm[5:0], req_rn, req_rd};
            end
            3'd1: begin
                enc_err  = simm < -64'sd2048 || simm > 64'sd2047;
                enc_word = {req_opcode[10:1], req_imm[11:0], req_rn, req_rd};
            end
            3'd2: begin
                enc_err  = simm < -64'sd256 || simm > 64'sd255;
                enc_word = {req_opcode, req_imm[8:0], 2'b00, req_rn, req_rd};
            end
            3'd3: begin
                enc_err  = simm < -64'sd262144 || simm > 64'sd262143;
                enc_word = {req_opcode[10:3], req_imm[18:0], req_rd};
            end
            3'd4: begin
                enc_err  = simm < -64'sd33554432 || simm > 64'sd33554431;
                enc_word = {req_opcode[10:5], req_imm[25:0]};
            end
            3'd5: enc_word = wide_first;
            default: enc_err = 1'b1;
        endcase
        if (enc_err) enc_word = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = state == IDLE;
        out_valid = state != IDLE;
        case (state)
            IDLE:    if (req_valid) state_nxt = req_fmt == 3'd5 ? WIDE : HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            WIDE:    if (out_ready && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign accept  = req_valid && req_ready;
    assign advance = state == WIDE && out_ready && !out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_instr <= '0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            wimm      <= '0;
            wrd       <= '0;
            rem       <= '0;
        end else if (accept) begin
            out_instr <= enc_word;
            out_err   <= enc_err;
            out_last  <= req_fmt != 3'd5 || first_rem == 4'd0;
            wimm      <= req_imm;
            wrd       <= req_rd;
            rem       <= req_fmt == 3'd5 ? first_rem : 4'd0;
        end else if (advance) begin
            out_instr <= wide_next;
            out_last  <= rem_nxt == 4'd0;
            rem       <= rem_nxt;
        end
    end

`ifdef IMM_ENC_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_words <= '0;
            perf_errs  <= '0;
        end else if (out_valid && out_ready) begin
            if (!(&perf_words)) perf_words <= perf_words + 32'd1;
            if (out_err && !(&perf_errs)) perf_errs <= perf_errs + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: randomized and directed checks of imm_encoder against an arithmetic field-packing model.
module tb_imm_encoder;
    logic        clk = 0, rst_n = 0, req_valid = 0, out_ready = 0;
    logic        req_ready, out_valid, out_last, out_err;
    logic [2:0]  req_fmt = 0;
    logic [10:0] req_opcode = 0;
    logic [4:0]  req_rd = 0, req_rn = 0;
    logic [63:0] req_imm = 0;
    logic [31:0] out_instr;
`ifdef IMM_ENC_PERF_EN
    logic [31:0] perf_words;
    logic [15:0] perf_errs;
`endif

    imm_encoder dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_fmt(req_fmt), .req_opcode(req_opcode), .req_rd(req_rd), .req_rn(req_rn),
        .req_imm(req_imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_last(out_last), .out_err(out_err)
`ifdef IMM_ENC_PERF_EN
        , .perf_words(perf_words), .perf_errs(perf_errs)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] w; logic last; logic err;} exp_t;
    exp_t q[$];
    int   tests = 0, fails = 0, rdy_mode = 0;

    localparam logic [10:0] ADDI = 11'b10010001000;
    localparam logic [10:0] CBZ  = 11'b10110100000;
    localparam logic [10:0] LDUR = 11'b11111000010;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Field packing by plain shifts/masks; ranges straight from the field widths
    function automatic void model(input int fmt, input logic [10:0] op, input logic [4:0] rd,
                                  input logic [4:0] rn, input longint imm);
        longint o = longint'(op), d = longint'(rd), n = longint'(rn), lo = 0, hi = 0, w = 0;
        int hws[$];
        case (fmt)
            0: begin lo = 0; hi = 63; w = (o << 21) | ((imm & 63) << 10) | (n << 5) | d; end
            1: begin lo = -2048; hi = 2047; w = ((o >> 1) << 22) | ((imm & 'hFFF) << 10) | (n << 5) | d; end
            2: begin lo = -256; hi = 255; w = (o << 21) | ((imm & 'h1FF) << 12) | (n << 5) | d; end
            3: begin lo = -(1 << 18); hi = (1 << 18) - 1; w = ((o >> 3) << 24) | ((imm & 'h7FFFF) << 5) | d; end
            4: begin lo = -(1 << 25); hi = (1 << 25) - 1; w = ((o >> 5) << 26) | (imm & 'h3FFFFFF); end
            5: begin
                for (int k = 0; k < 4; k++) if (((imm >> (16 * k)) & 'hFFFF) != 0) hws.push_back(k);
                if (hws.size() == 0) hws.push_back(0);
                for (int k = 0; k < hws.size(); k++) begin
                    w = ((k == 0 ? longint'('h1A5) : longint'('h1E5)) << 23) | (longint'(hws[k]) << 21)
                        | (((imm >> (16 * hws[k])) & 'hFFFF) << 5) | d;
                    q.push_back({w[31:0], k == hws.size() - 1, 1'b0});
                end
                return;
            end
            default: begin q.push_back({32'h0, 1'b1, 1'b1}); return; end
        endcase
        if (imm < lo || imm > hi) q.push_back({32'h0, 1'b1, 1'b1});
        else q.push_back({w[31:0], 1'b1, 1'b0});
    endfunction

    initial forever begin
        @(posedge clk);
        #1 out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    logic        stall_prev = 0;
    logic [33:0] prev = 0;
    always @(negedge clk) begin
        if (!rst_n) stall_prev = 0;
        else begin
            if (out_valid) begin
                chk("ready_while_busy", req_ready, 0);
                if (stall_prev) chk("stall_stable", {out_instr, out_last, out_err}, prev);
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL extra_word: got %h expected no word", out_instr);
                end else begin
                    chk("instr", out_instr, q[0].w);
                    chk("last", out_last, q[0].last);
                    chk("err", out_err, q[0].err);
                    if (out_ready) void'(q.pop_front());
                end
            end
            stall_prev = out_valid && !out_ready;
            prev = {out_instr, out_last, out_err};
        end
    end

    task automatic send(input int fmt, input logic [10:0] op, input logic [4:0] rd,
                        input logic [4:0] rn, input longint imm);
        int n = 0;
        @(posedge clk);
        #1 req_fmt = fmt[2:0]; req_opcode = op; req_rd = rd; req_rn = rn; req_imm = imm; req_valid = 1;
        @(negedge clk);
        while (!req_ready && n < 300) begin @(negedge clk); n++; end
        if (!req_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1");
            req_valid = 0;
            return;
        end
        @(posedge clk);
        model(fmt, op, rd, rn, imm);
        #1 req_valid = 0;
        @(negedge clk);
        chk("valid_after_accept", out_valid, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 400) begin @(negedge clk); n++; end
        chk("drain_pending", q.size(), 0);
        @(negedge clk);
        chk("idle_after_drain", {out_valid, req_ready}, 2'b01);
    endtask

    int     ef[21] = '{2, 2, 2, 2, 4, 4, 4, 1, 1, 1, 1, 0, 0, 0, 0, 3, 3, 3, 6, 7, 5};
    longint ei[21] = '{-256, -257, 255, 256, 64'sd33554432, -64'sd33554432, 64'sd33554431,
                       2047, 2048, -2048, -2049, 63, 64, -1, 0, 262143, 262144, -262144, 0, 5,
                       64'sh8000000000000000};
    longint bnd[5] = '{63, 2047, 255, 262143, 33554431};

    initial begin
        longint imm, b;
        int     fmt;
        model(1, ADDI, 2, 1, 5);
        chk("pin_addi", {q[0].w, q[0].last, q[0].err}, {32'h91001422, 2'b10});
        q.delete();
        model(3, CBZ, 5, 0, -1);
        chk("pin_cbz", {q[0].w, q[0].last, q[0].err}, {32'hB4FFFFE5, 2'b10});
        q.delete();
        model(5, 0, 3, 0, 64'h0001_0000_0000_BEEF);
        chk("pin_wide_n", q.size(), 2);
        chk("pin_wide", {q[0].w, q[0].last, q[1].w, q[1].last}, {32'hD297DDE3, 1'b0, 32'hF2E00023, 1'b1});
        q.delete();
        model(5, 0, 3, 0, 0);
        chk("pin_wide0", {q.size() == 1, q[0].w, q[0].last}, {1'b1, 32'hD2800003, 1'b1});
        q.delete();
        model(2, LDUR, 0, 0, -257);
        chk("pin_d_err", {q[0].w, q[0].last, q[0].err}, {32'h0, 2'b11});
        q.delete();

        repeat (3) @(negedge clk);
        chk("rst_state", {req_ready, out_valid, out_instr, out_last, out_err}, {2'b10, 32'h0, 2'b00});
        rst_n = 1;

        send(1, ADDI, 2, 1, 5);
        chk("addi_word", {out_instr, out_last, out_err}, {32'h91001422, 2'b10});
        drain();
        send(3, CBZ, 5, 0, -1);
        chk("cbz_word", {out_instr, out_last}, {32'hB4FFFFE5, 1'b1});
        drain();
        send(5, 0, 3, 0, 64'h0001_0000_0000_BEEF);
        chk("wide_first", {out_instr, out_last}, {32'hD297DDE3, 1'b0});
        drain();
        send(5, 0, 3, 0, 0);
        chk("wide_zero", {out_instr, out_last}, {32'hD2800003, 1'b1});
        drain();
        send(2, LDUR, 1, 2, -257);
        chk("d_oor", {out_instr, out_err, out_last}, {32'h0, 2'b11});
        drain();
        for (int i = 0; i < 21; i++) begin
            send(ef[i], 11'($urandom), 5'($urandom), 5'($urandom), ei[i]);
            drain();
        end

        rdy_mode = 2;
        send(5, 0, 7, 0, -1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_ready_low", {req_ready, out_valid, out_last}, 3'b010);
        end
        rdy_mode = 0;
        drain();

        send(5, 0, 9, 0, -1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 0;
        #1 chk("midseq_reset", {out_valid, req_ready, out_instr}, {2'b01, 32'h0});
        q.delete();
        @(negedge clk);
        rst_n = 1;
        send(2, LDUR, 4, 6, -256);
        drain();

        rdy_mode = 1;
        repeat (200) begin
            fmt = $urandom_range(0, 7);
            case ($urandom_range(0, 3))
                0: imm = longint'($urandom_range(0, 600)) - 300;
                1: begin
                    b = bnd[fmt < 5 ? fmt : 0];
                    imm = $urandom_range(0, 1) ? b + $urandom_range(0, 1) : -b - 1 - $urandom_range(0, 1);
                end
                2: imm = longint'({$urandom, $urandom});
                default: begin
                    imm = 0;
                    for (int k = 0; k < 4; k++)
                        if ($urandom_range(0, 1)) imm |= longint'($urandom_range(0, 65535)) << (16 * k);
                end
            endcase
            send(fmt, 11'($urandom), 5'($urandom), 5'($urandom), imm);
        end
        rdy_mode = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
